// File: rtl/lab4_sys_net_req_tracker.sv
// Bank-side network endpoint: tags each incoming cache request, forwards it to the
// bank, and on the bank's response restores the requester's header and opaque bits.
module lab4_sys_net_req_tracker #(
    parameter  int NUM_TAGS = 4,
    localparam int HDR_W    = 12,
    localparam int REQ_W    = 77,
    localparam int RESP_W   = 47,
    localparam int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [HDR_W+REQ_W-1:0]  netreq_msg,
    input  logic                    netreq_val,
    output logic                    netreq_rdy,
    output logic [REQ_W-1:0]        cachereq_msg,
    output logic                    cachereq_val,
    input  logic                    cachereq_rdy,
    input  logic [RESP_W-1:0]       cacheresp_msg,
    input  logic                    cacheresp_val,
    output logic                    cacheresp_rdy,
    output logic [HDR_W+RESP_W-1:0] netresp_msg,
    output logic                    netresp_val,
    input  logic                    netresp_rdy,
    output logic [TAG_W:0]          num_outstanding,
    output logic                    tag_err
);

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] dest;
        logic [7:0] opaque;
    } net_hdr_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    net_hdr_t     req_hdr;
    mem_req_4B_t  req_pay;
    mem_resp_4B_t resp_in;

    assign req_hdr = netreq_msg[HDR_W+REQ_W-1:REQ_W];
    assign req_pay = netreq_msg[REQ_W-1:0];
    assign resp_in = cacheresp_msg;

    logic [NUM_TAGS-1:0] valid_q;
    logic [1:0]          src_tbl    [NUM_TAGS];
    logic [1:0]          dest_tbl   [NUM_TAGS];
    logic [7:0]          hdr_op_tbl [NUM_TAGS];
    logic [7:0]          req_op_tbl [NUM_TAGS];

    logic             has_free;
    logic [TAG_W-1:0] free_tag;
    logic [TAG_W:0]   valid_cnt;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        has_free  = 1'b0;
        free_tag  = '0;
        valid_cnt = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_tag = TAG_W'(i);
            end
            valid_cnt = valid_cnt + (TAG_W+1)'(valid_q[i]);
        end
    end

    assign num_outstanding = valid_cnt;

    logic req_go;
    assign netreq_rdy = has_free && (!cachereq_val || cachereq_rdy);
    assign req_go     = netreq_val && netreq_rdy;

    logic [TAG_W-1:0] resp_tag;
    logic             resp_go;
    logic             resp_take;

    assign cacheresp_rdy = !netresp_val || netresp_rdy;
    assign resp_go       = cacheresp_val && cacheresp_rdy;
    assign resp_tag      = resp_in.opaque[TAG_W-1:0];
    // Opaque bits above the index must be zero, otherwise the tag is bogus.
    assign resp_take     = resp_go && valid_q[resp_tag] && ((resp_in.opaque >> TAG_W) == 8'd0);

    mem_req_4B_t  creq_d;
    net_hdr_t     nresp_hdr;
    mem_resp_4B_t nresp_pay;

    always_comb begin
        creq_d           = req_pay;
        creq_d.opaque    = 8'(free_tag);
        nresp_hdr.src    = dest_tbl[resp_tag];
        nresp_hdr.dest   = src_tbl[resp_tag];
        nresp_hdr.opaque = hdr_op_tbl[resp_tag];
        nresp_pay        = resp_in;
        nresp_pay.opaque = req_op_tbl[resp_tag];
    end

    // NOTE: table payload and message registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (req_go) begin
            src_tbl[free_tag]    <= req_hdr.src;
            dest_tbl[free_tag]   <= req_hdr.dest;
            hdr_op_tbl[free_tag] <= req_hdr.opaque;
            req_op_tbl[free_tag] <= req_pay.opaque;
            cachereq_msg         <= creq_d;
        end
        if (resp_take) begin
            netresp_msg <= {nresp_hdr, nresp_pay};
        end
    end

    // Allocation reads the registered vector, so a tag freed this cycle is not reused until the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            cachereq_val <= 1'b0;
            netresp_val  <= 1'b0;
            tag_err      <= 1'b0;
        end else begin
            if (req_go) begin
                valid_q[free_tag] <= 1'b1;
            end
            if (resp_take) begin
                valid_q[resp_tag] <= 1'b0;
            end

            if (req_go) begin
                cachereq_val <= 1'b1;
            end else if (cachereq_rdy) begin
                cachereq_val <= 1'b0;
            end

            if (resp_take) begin
                netresp_val <= 1'b1;
            end else if (netresp_rdy) begin
                netresp_val <= 1'b0;
            end

            tag_err <= resp_go && !resp_take;
        end
    end

endmodule
